// File: rtl/scatter2d_engine_if.sv
// ---------------------------------------------------------------------------
// scatter2d_engine_if
// Memory write port of the scatter engine: a valid/ready beat channel that
// carries one 32-bit word and its byte address per accepted beat.
//   m_valid  master->slave  beat valid (held with address/data until accepted)
//   m_ready  slave->master  sink accepts the beat when m_valid && m_ready
//   m_addr   master->slave  byte address of the beat
//   m_data   master->slave  write data
// ---------------------------------------------------------------------------
interface scatter2d_engine_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  modport master (
    output m_valid,
    output m_addr,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_addr,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/scatter2d_engine.sv
// ---------------------------------------------------------------------------
// scatter2d_engine
// Streams the O scratchpad row by row to destination memory rows selected by
// the index RAM. Each read of the O buffer is tagged with its destination
// address; returning words are queued in a 2-entry FIFO that feeds the
// valid/ready write port.
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   start                  begin a scatter (only honoured in IDLE)
//   s_tokens, head_dim_d   rows and words per row, latched at accepted start
//   base_addr              destination byte base, latched at accepted start
//   o_ren/o_raddr/o_rdata  O buffer read port, data one cycle after o_ren
//   idx_rd_addr/_data      index RAM read port, combinational data
//   wr                     write beat channel (master side)
//   busy                   high while running or draining
//   done                   one-cycle completion pulse
// ---------------------------------------------------------------------------
module scatter2d_engine (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [15:0]               s_tokens,
  input  logic [15:0]               head_dim_d,
  input  logic [31:0]               base_addr,
  output logic                      o_ren,
  output logic [15:0]               o_raddr,
  input  logic [31:0]               o_rdata,
  output logic [15:0]               idx_rd_addr,
  input  logic [15:0]               idx_rd_data,
  scatter2d_engine_if.master        wr,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [15:0] tokens_r;
  logic [15:0] dim_r;
  logic [31:0] base_r;
  logic [15:0] tok_r;
  logic [15:0] d_r;
  logic [15:0] lin_r;
  logic        busy_r;
  logic        done_r;

  logic        inflight_r;
  logic [31:0] tag_addr_r;

  logic [31:0] fifo_addr_r [2];
  logic [31:0] fifo_data_r [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  occ_r;

  logic        pop_s;
  logic        push_s;
  logic [2:0]  need_s;
  logic        issue_s;
  logic        last_s;
  logic [31:0] entry_addr_s;
  logic [1:0]  occ_next_s;

  // Handshake and credit: a read may issue only if its word is guaranteed a
  // FIFO slot, counting the word still in flight and any pop this cycle.
  always_comb begin
    pop_s        = (occ_r != 2'd0) && wr.m_ready;
    push_s       = inflight_r;
    need_s       = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s      = (state_r == ST_RUN) && (need_s < 3'd2);
    last_s       = (tok_r == (tokens_r - 16'd1)) && (d_r == (dim_r - 16'd1));
    entry_addr_s = base_r +
                   ((({16'h0000, idx_rd_data} * {16'h0000, dim_r}) + {16'h0000, d_r}) << 2);
  end

  // FIFO occupancy update; push and pop together leave it unchanged.
  always_comb begin
    occ_next_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + 2'd1;
      2'b01:   occ_next_s = occ_r - 2'd1;
      default: occ_next_s = occ_r;
    endcase
  end

  assign o_ren       = issue_s;
  assign o_raddr     = lin_r;
  assign idx_rd_addr = (state_r == ST_RUN) ? tok_r : 16'h0000;
  assign wr.m_valid  = (occ_r != 2'd0);
  assign wr.m_addr   = fifo_addr_r[rd_ptr_r];
  assign wr.m_data   = fifo_data_r[rd_ptr_r];
  assign busy        = busy_r;
  assign done        = done_r;

  // Control FSM: latches the job, walks tok/d, and drives busy/done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_IDLE;
      tokens_r <= 16'h0000;
      dim_r    <= 16'h0000;
      base_r   <= 32'h0000_0000;
      tok_r    <= 16'h0000;
      d_r      <= 16'h0000;
      lin_r    <= 16'h0000;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            tokens_r <= s_tokens;
            dim_r    <= head_dim_d;
            base_r   <= base_addr;
            tok_r    <= 16'h0000;
            d_r      <= 16'h0000;
            lin_r    <= 16'h0000;
            if ((s_tokens != 16'h0000) && (head_dim_d != 16'h0000)) begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end else begin
              // Empty job: report completion without touching memory.
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (issue_s) begin
            lin_r <= lin_r + 16'd1;
            if (d_r == (dim_r - 16'd1)) begin
              d_r   <= 16'h0000;
              tok_r <= tok_r + 16'd1;
            end else begin
              d_r <= d_r + 16'd1;
            end
            if (last_s) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Finish once the last queued beat leaves and nothing is returning.
          if (!inflight_r && (occ_r == {1'b0, pop_s})) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // In-flight tag: destination address of the word returning next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_r <= 1'b0;
      tag_addr_r <= 32'h0000_0000;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        tag_addr_r <= entry_addr_s;
      end else begin
        tag_addr_r <= tag_addr_r;
      end
    end
  end

  // Two-entry write FIFO holding address/data pairs for the write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        fifo_addr_r[i] <= 32'h0000_0000;
        fifo_data_r[i] <= 32'h0000_0000;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= tag_addr_r;
        fifo_data_r[wr_ptr_r] <= o_rdata;
        wr_ptr_r              <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      occ_r <= occ_next_s;
    end
  end

endmodule

// File: tb/tb_scatter2d_engine.sv
module tb_scatter2d_engine;
  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] s_tokens;
  logic [15:0] head_dim_d;
  logic [31:0] base_addr;
  logic        o_ren;
  logic [15:0] o_raddr;
  logic [31:0] o_rdata;
  logic [15:0] idx_rd_addr;
  logic [15:0] idx_rd_data;
  logic        busy;
  logic        done;

  scatter2d_engine_if wr();

  scatter2d_engine dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .s_tokens    (s_tokens),
    .head_dim_d  (head_dim_d),
    .base_addr   (base_addr),
    .o_ren       (o_ren),
    .o_raddr     (o_raddr),
    .o_rdata     (o_rdata),
    .idx_rd_addr (idx_rd_addr),
    .idx_rd_data (idx_rd_data),
    .wr          (wr.master),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Memories seen by the engine
  logic [15:0] idx_mem [0:255];
  logic [31:0] o_salt;
  logic [31:0] o_mul;
  assign idx_rd_data = idx_mem[idx_rd_addr[7:0]];

  function automatic logic [31:0] obuf(input logic [15:0] a);
    return o_salt + ({16'h0000, a} * o_mul);
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard state
  int          cyc = 0;
  bit          mon_en = 1'b0;
  longint      issued, acc, valid_cycles;
  int          first_ren_cyc, first_val_cyc, last_acc_cyc;
  longint      max_out;
  logic [63:0] exp_q[$];
  bit          prev_stall;
  logic [31:0] prev_addr, prev_data;
  int          ready_mode = 0;
  int          stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready pattern
  initial begin
    wr.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: wr.m_ready = 1'b1;
        1: wr.m_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (acc == 2 && stall_left > 0) begin
            wr.m_ready = 1'b0;
            stall_left--;
          end else begin
            wr.m_ready = 1'b1;
          end
        end
        default: wr.m_ready = 1'b1;
      endcase
    end
  end

  // O buffer: data valid the cycle after o_ren
  initial begin
    logic        rq;
    logic [15:0] aq;
    o_rdata = 32'h0;
    forever begin
      @(negedge clk);
      rq = o_ren;
      aq = o_raddr;
      @(posedge clk);
      #1;
      o_rdata = rq ? obuf(aq) : 32'hDEAD_BEEF;
    end
  end

  // Beat monitor against the expected queue
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rstn) begin
        if (o_ren) begin
          if (issued == 0) first_ren_cyc = cyc;
          issued++;
        end
        if (wr.m_valid) begin
          if (valid_cycles == 0) first_val_cyc = cyc;
          valid_cycles++;
        end
        if (prev_stall) begin
          chk("hold_addr", {31'h0, wr.m_valid, wr.m_addr}, {31'h0, 1'b1, prev_addr});
          chk("hold_data", wr.m_data, prev_data);
        end
        if (wr.m_valid && wr.m_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", acc + 1, acc);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", wr.m_addr, e[63:32]);
            chk("beat_data", wr.m_data, e[31:0]);
          end
          acc++;
          last_acc_cyc = cyc;
        end
        prev_stall = wr.m_valid && !wr.m_ready;
        prev_addr  = wr.m_addr;
        prev_data  = wr.m_data;
        if (issued - acc > max_out) max_out = issued - acc;
        chk("credit", {63'h0, (issued - acc) > 2}, 64'h0);
      end
    end
  end

  task automatic run(input int nt, input int nd, input logic [31:0] base,
                     input int rmode, input bit perturb);
    longint      total;
    longint      a64;
    int          lin;
    bit          timed_out;
    @(posedge clk);
    #1;
    exp_q.delete();
    issued = 0; acc = 0; valid_cycles = 0; max_out = 0; prev_stall = 1'b0;
    first_ren_cyc = 0; first_val_cyc = 0; last_acc_cyc = 0;
    ready_mode = rmode; stall_left = 5; mon_en = 1'b1;
    total = longint'(nt) * longint'(nd);
    lin = 0;
    for (int t = 0; t < nt; t++) begin
      for (int d = 0; d < nd; d++) begin
        a64 = longint'(base) + (longint'(idx_mem[t]) * nd + d) * 4;
        exp_q.push_back({a64[31:0], obuf(lin[15:0])});
        lin++;
      end
    end
    @(negedge clk);
    start = 1'b1; s_tokens = nt[15:0]; head_dim_d = nd[15:0]; base_addr = base;
    @(negedge clk);
    start = 1'b0;
    if (total == 0) begin
      chk("zl_done", done, 1);
      chk("zl_busy", busy, 0);
      @(negedge clk);
      chk("zl_done_pulse", done, 0);
      chk("zl_busy2", busy, 0);
      chk("zl_reads", issued, 0);
      chk("zl_valid", valid_cycles, 0);
      return;
    end
    chk("run_busy", busy, 1);
    chk("run_first_ren", o_ren, 1);
    chk("run_idx_addr", idx_rd_addr, 0);
    if (perturb) begin
      start = 1'b1; s_tokens = nt[15:0] + 16'd5; head_dim_d = nd[15:0] + 16'd3; base_addr = ~base;
      @(negedge clk);
      start = 1'b0;
    end
    timed_out = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (acc >= total) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk("timeout", timed_out, 0);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("end_busy", busy, 0);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("idle_valid", wr.m_valid, 0);
    chk("beats", acc, total);
    chk("reads", issued, total);
    chk("q_left", exp_q.size(), 0);
    chk("first_valid_lat", first_val_cyc - first_ren_cyc, 2);
    if (rmode == 0) chk("throughput", last_acc_cyc - first_val_cyc, total - 1);
    if (rmode == 2) chk("fifo_full", max_out, 2);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {o_ren, o_raddr, idx_rd_addr, wr.m_valid, busy, done},
        {1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0});
    chk({tag, "_beat"}, {wr.m_addr, wr.m_data}, 64'h0);
  endtask

  initial begin
    bit seen_valid;
    rstn = 1'b0; start = 1'b0; s_tokens = 16'h0; head_dim_d = 16'h0; base_addr = 32'h0;
    o_salt = 32'h0000_A000; o_mul = 32'h1;
    for (int i = 0; i < 256; i++) idx_mem[i] = 16'h0;
    idx_mem[0] = 16'd5; idx_mem[1] = 16'd9;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;

    run(2, 4, 32'h0000_1000, 0, 1'b0);   // directed 8 beats
    run(2, 4, 32'h0000_1000, 2, 1'b0);   // 5-cycle stall after beat 2
    run(0, 16, 32'h0000_1000, 0, 1'b0);  // zero-length
    run(2, 4, 32'h0000_1000, 0, 1'b1);   // ignored restart / input changes

    // Reset while a beat is pending
    @(posedge clk); #1;
    mon_en = 1'b0; ready_mode = 2; stall_left = 100; acc = 2;
    @(negedge clk);
    start = 1'b1; s_tokens = 16'd3; head_dim_d = 16'd4; base_addr = 32'h2000;
    @(negedge clk);
    start = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr.m_valid) begin
        seen_valid = 1'b1;
        break;
      end
    end
    chk("rst_saw_valid", seen_valid, 1);
    #2 rstn = 1'b0;
    #1 check_outputs_zero("midrun_reset");
    @(negedge clk);
    rstn = 1'b1;
    acc = 0;
    idx_mem[0] = 16'd0;
    run(1, 2, 32'h0000_0000, 0, 1'b0);

    run(1, 8, 32'hFFFF_FFF0, 0, 1'b0);   // address wrap

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 8; i++) idx_mem[i] = 16'($urandom);
      o_salt = $urandom;
      o_mul  = $urandom | 32'h1;
      run($urandom_range(0, 6), $urandom_range(1, 6), $urandom, $urandom_range(0, 1), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/scatter2d_engine.md
# scatter2d_engine

Block-structured scatter engine for the attention core's write-back path. It streams the output scratchpad (O buffer) row by row. Each token row goes to the memory row named by the index RAM, and every word leaves through a valid/ready memory write port. It is the write-back counterpart of the gather path that fills the Q/K scratchpads, and it shares the same index RAM addressing.

## Interface
- No parameters; all widths fixed as below.
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin a scatter; sampled only in IDLE
- s_tokens  in  16  token rows to scatter; latched at accepted start
- head_dim_d  in  16  words per row; latched at accepted start
- base_addr  in  32  byte base of destination; latched at accepted start
- o_ren  out  1  O buffer read enable
- o_raddr  out  16  O buffer word address
- o_rdata  in  32  O buffer data, valid exactly 1 cycle after o_ren
- idx_rd_addr  out  16  index RAM address (current token)
- idx_rd_data  in  16  index RAM data, combinational same-cycle
- m_valid  out  1  write beat valid
- m_ready  in  1  sink accepts beat when m_valid && m_ready
- m_addr  out  32  byte address of beat
- m_data  out  32  write data
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start when latched s_tokens≠0 and head_dim_d≠0.
  - IDLE→DONE on start when either is 0; no reads and no beats occur.
  - RUN→DRAIN in the cycle after the last read issues.
  - DRAIN→DONE when the queue is empty and no read is in flight.
  - DONE→IDLE unconditionally.
- start is ignored outside IDLE. Input changes after start have no effect.
- Iteration: tok 0..s_tokens-1 outer, d 0..head_dim_d-1 inner. A linear counter lin starts at 0 and increments per issued read.
- Issue in RUN:
  - o_ren=1, o_raddr=lin[15:0], which wraps modulo 2^16.
  - idx_rd_addr=tok.
  - idx_rd_data and d are captured into an in-flight tag.
- Returning o_rdata plus its tag are written into a 2-entry FIFO.
  - Entry address = base_addr + ((idx*head_dim_d + d) << 2). The product is 32-bit; the sum and shift are truncated modulo 2^32.
- m_valid = FIFO not empty. m_addr/m_data come from the FIFO head. A pop happens on m_valid && m_ready.
- Issue condition: state==RUN && (occupancy + inflight − pop) < 2. inflight=1 if o_ren was high last cycle.
- Once m_valid is asserted, m_addr and m_data hold stable until accepted.
- Total beats = s_tokens*head_dim_d, in order, with no loss or duplication.
- idx_rd_addr = tok in RUN, 0 otherwise.

## Timing
- Reset values: o_ren=0, o_raddr=0, idx_rd_addr=0, m_valid=0, m_addr=0, m_data=0, busy=0, done=0. FIFO, counters and tags are cleared.
- Reset mid-operation: everything is cleared asynchronously and pending beats are discarded. Operation resumes in IDLE after release.
- start high at edge N (IDLE): state is RUN in cycle N+1, and the first o_ren is in cycle N+1.
- The first m_valid comes 2 cycles after the first o_ren.
- With m_ready held at 1, sustained throughput is 1 beat/cycle.
- done is asserted in the cycle after the last beat is accepted (the DONE state).
- Zero-length start at edge N: done=1 in cycle N+1, busy stays 0.
- Backpressure: FIFO occupancy never exceeds 2, and o_ren stays low while credit is exhausted.
- Simultaneous push and pop on a full FIFO is legal. Occupancy is unchanged.

## Test plan
- s_tokens=2, D=4, base 0x1000, idx={5,9}, O[i]=0xA000+i, m_ready=1 -> 8 beats:
  - addrs 0x1050,0x1054,0x1058,0x105C,0x1090,0x1094,0x1098,0x109C
  - data 0xA000..0xA007
  - first m_valid 2 cycles after first o_ren
  - single-cycle done after last beat
- Same setup, m_ready low for 5 cycles after beat 2 -> o_ren drops within 1 cycle, FIFO holds 2 entries, m_addr/m_data stable while stalled, all 8 beats in order, none lost or duplicated.
- start with s_tokens=0, D=16 -> done=1 exactly one cycle after start, busy=0, no o_ren, no m_valid.
- Second start pulse and changed s_tokens/base_addr during RUN -> ignored; beat count and addresses match the first latched values.
- rstn low while m_valid=1 mid-run -> all outputs 0 immediately. After release, a new start (s_tokens=1, D=2, idx=0, base 0) yields exactly 2 beats at 0x0 and 0x4.
- base 0xFFFFFFF0, idx=0, D=8, s_tokens=1 -> addrs 0xFFFFFFF0..0xFFFFFFFC, then 0x0, 0x4, 0x8, 0xC (mod 2^32 wrap).
